// File: rtl/ex_result_stage_pkg.sv
// Shared types for the execute-stage result buffer: condition and overflow-check
// encodings, buffer depth and the signed-overflow helper.
package ex_result_stage_pkg;

    typedef enum logic [2:0] {
        COND_EQ = 3'd0,
        COND_LT = 3'd1,
        COND_NE = 3'd2,
        COND_LE = 3'd3,
        COND_GT = 3'd4,
        COND_GE = 3'd5,
        COND_HI = 3'd6,
        COND_HE = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        OVL_NONE = 2'd0,
        OVL_SGN  = 2'd1,
        OVL_UADD = 2'd2,
        OVL_USUB = 2'd3
    } ovl_e;

    localparam int DEPTH = 2;

    // Two's-complement overflow: operands agree in sign, result sign differs.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic msb);
        return (sa == sb) && (msb != sa);
    endfunction

endpackage

// File: rtl/ex_result_stage_cond_eval.sv
// Combinational evaluation of the instruction's compare condition and the
// arithmetic-overflow trap from the ALU status flags.
module ex_result_stage_cond_eval
    import ex_result_stage_pkg::*;
(
    input  logic       c,
    input  logic       n,
    input  logic       z,
    input  logic       sa,
    input  logic       sb,
    input  logic       msb,
    input  logic [2:0] cond,
    input  logic [1:0] ovl,
    output logic       cond_true,
    output logic       trap
);

    logic v;
    logic lt;

    assign v  = signed_ovf(sa, sb, msb);
    assign lt = n ^ v;

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_true = z;
            COND_LT: cond_true = lt;
            COND_NE: cond_true = ~z;
            COND_LE: cond_true = lt | z;
            COND_GT: cond_true = ~(lt | z);
            COND_GE: cond_true = ~lt;
            COND_HI: cond_true = c & ~z;
            COND_HE: cond_true = c;
        endcase
    end

    always_comb begin
        trap = 1'b0;
        case (ovl_e'(ovl))
            OVL_NONE: trap = 1'b0;
            OVL_SGN:  trap = v;
            OVL_UADD: trap = c;
            OVL_USUB: trap = ~c;
        endcase
    end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage result buffer: captures ALU results with condition/trap status into
// a 2-entry skid FIFO towards write-back and offers a register-forwarding lookup.
module ex_result_stage
    import ex_result_stage_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:WIDTH-1]  in_res,
    input  logic              in_c,
    input  logic              in_n,
    input  logic              in_z,
    input  logic              in_sa,
    input  logic              in_sb,
    input  logic [2:0]        in_cond,
    input  logic [1:0]        in_ovl,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:WIDTH-1]  out_res,
    output logic [RIDX_W-1:0] out_rd,
    output logic              out_wen,
    output logic              out_cond,
    output logic              out_trap,
    input  logic [RIDX_W-1:0] q_rd,
    output logic              q_hit,
    output logic [0:WIDTH-1]  q_res
);

    typedef struct packed {
        logic [0:WIDTH-1]  res;
        logic [RIDX_W-1:0] rd;
        logic              wen;
        logic              cond;
        logic              trap;
    } entry_t;

    entry_t     ent_reg [DEPTH];
    logic       head_reg;
    logic [1:0] count_reg;

    logic   cond_true;
    logic   trap;
    logic   push;
    logic   pop;
    logic   tail;
    entry_t new_ent;
    entry_t head_ent;

    ex_result_stage_cond_eval u_cond_eval (
        .c         (in_c),
        .n         (in_n),
        .z         (in_z),
        .sa        (in_sa),
        .sb        (in_sb),
        .msb       (in_res[0]),
        .cond      (in_cond),
        .ovl       (in_ovl),
        .cond_true (cond_true),
        .trap      (trap)
    );

    assign in_ready = (count_reg < 2'd2);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    // Next free slot; with one entry it is the slot after head, even when head pops.
    assign tail     = head_reg ^ count_reg[0];

    always_comb begin
        new_ent      = '0;
        new_ent.res  = in_res;
        new_ent.rd   = in_rd;
        new_ent.wen  = in_wen & ~trap;
        new_ent.cond = cond_true;
        new_ent.trap = trap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= 1'b0;
            count_reg <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= '0;
            end
        end else if (flush) begin
            count_reg <= 2'd0;
        end else begin
            if (push) begin
                ent_reg[tail] <= new_ent;
            end
            if (pop) begin
                head_reg <= ~head_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_ent  = ent_reg[head_reg];
    assign out_valid = (count_reg != 2'd0);
    assign out_res   = out_valid ? head_ent.res  : '0;
    assign out_rd    = out_valid ? head_ent.rd   : '0;
    assign out_wen   = out_valid & head_ent.wen;
    assign out_cond  = out_valid & head_ent.cond;
    assign out_trap  = out_valid & head_ent.trap;

    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] fwd_match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fwd
            assign ent_vld[gi]   = (count_reg == 2'd2) ||
                                   ((count_reg == 2'd1) && (head_reg == 1'(gi)));
            assign fwd_match[gi] = ent_vld[gi] && ent_reg[gi].wen && (ent_reg[gi].rd == q_rd);
        end
    endgenerate

    // The non-head slot is only valid when full, and then it holds the younger entry.
    always_comb begin
        q_res = '0;
        if (fwd_match[head_reg]) begin
            q_res = ent_reg[head_reg].res;
        end
        if (fwd_match[~head_reg]) begin
            q_res = ent_reg[~head_reg].res;
        end
    end

    assign q_hit = |fwd_match;

endmodule
